// File: rtl/plru_tree.sv
// Tree pseudo-LRU engine for one cache set: walks one tree level per clock for a hit, fill or victim search.
// Define PLRU_ERR_EN to add the err output that flags illegal hit/miss pairs and out-of-range hits.
module plru_tree #(
    parameter  int SETWAY      = 4,
    localparam int BITS_SETWAY = $clog2(SETWAY)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [BITS_SETWAY-1:0] line_num,
    input  logic [SETWAY-2:0]      bTree_in,
    input  logic                   hit,
    input  logic                   miss,
    input  logic [BITS_SETWAY:0]   linesInSet_in,
    output logic [SETWAY-2:0]      bTree_out,
    output logic                   bTree_valid,
    output logic [BITS_SETWAY-1:0] index_out,
`ifdef PLRU_ERR_EN
    output logic                   err,
`endif
    output logic                   busy
);

    localparam int LW     = BITS_SETWAY + 1;
    localparam int NODE_W = BITS_SETWAY + 1;
    localparam int LVL_W  = (BITS_SETWAY > 1) ? $clog2(BITS_SETWAY) : 1;

    typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

    state_t                   state_q, state_d;
    logic [SETWAY-2:0]        tree_q, tree_d;
    logic [NODE_W-1:0]        node_q, node_d;
    logic [LVL_W-1:0]         level_q, level_d;
    logic [BITS_SETWAY-1:0]   tgt_q, tgt_d;
    logic                     victim_q, victim_d;
    logic [SETWAY-2:0]        btree_q, btree_d;
    logic [BITS_SETWAY-1:0]   index_q, index_d;
    logic                     err_q, err_d;

    logic [BITS_SETWAY:0]     lines_cl;
    logic                     cur_bit;
    logic                     dir;
    logic [SETWAY-2:0]        tree_nxt;
    logic [NODE_W-1:0]        node_nxt;
    logic [NODE_W-1:0]        leaf;

    assign lines_cl = (linesInSet_in > LW'(SETWAY)) ? LW'(SETWAY) : linesInSet_in;

    // Hit/fill steer toward the target and victim search follows the stored bit;
    // in both cases the visited node is rewritten to point away from the chosen child.
    always_comb begin
        cur_bit = 1'b0;
        for (int n = 0; n < SETWAY - 1; n++) begin
            if (node_q == NODE_W'(n)) cur_bit = tree_q[n];
        end
        dir      = victim_q ? cur_bit : tgt_q[BITS_SETWAY-1];
        tree_nxt = tree_q;
        for (int n = 0; n < SETWAY - 1; n++) begin
            if (node_q == NODE_W'(n)) tree_nxt[n] = ~dir;
        end
        node_nxt = (node_q << 1) + NODE_W'(1) + NODE_W'(dir);
        leaf     = node_nxt - NODE_W'(SETWAY - 1);
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path can infer a latch.
        state_d  = state_q;
        tree_d   = tree_q;
        node_d   = node_q;
        level_d  = level_q;
        tgt_d    = tgt_q;
        victim_d = victim_q;
        btree_d  = btree_q;
        index_d  = index_q;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (hit ^ miss) begin
                    tree_d   = bTree_in;
                    node_d   = '0;
                    level_d  = '0;
                    victim_d = miss && (lines_cl == LW'(SETWAY));
                    tgt_d    = hit ? line_num : lines_cl[BITS_SETWAY-1:0];
                    state_d  = WALK;
                end
                if ((hit && miss) || (hit && !miss && ({1'b0, line_num} >= lines_cl)))
                    err_d = 1'b1;
            end
            WALK: begin
                tree_d  = tree_nxt;
                node_d  = node_nxt;
                tgt_d   = tgt_q << 1;
                level_d = level_q + LVL_W'(1);
                if (level_q == LVL_W'(BITS_SETWAY - 1)) begin
                    btree_d = tree_nxt;
                    index_d = leaf[BITS_SETWAY-1:0];
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            tree_q   <= '0;
            node_q   <= '0;
            level_q  <= '0;
            tgt_q    <= '0;
            victim_q <= 1'b0;
            btree_q  <= '0;
            index_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tree_q   <= tree_d;
            node_q   <= node_d;
            level_q  <= level_d;
            tgt_q    <= tgt_d;
            victim_q <= victim_d;
            btree_q  <= btree_d;
            index_q  <= index_d;
            err_q    <= err_d;
        end
    end

    assign bTree_out   = btree_q;
    assign index_out   = index_q;
    assign bTree_valid = (state_q == DONE);
    assign busy        = (state_q != IDLE);

`ifdef PLRU_ERR_EN
    assign err = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_plru_tree.sv
// Self-checking bench for plru_tree (SETWAY=4): directed vector table, corner sequences, randomized model check.
module tb_plru_tree;

    localparam int SETWAY = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] line_num = '0;
    logic [2:0] bTree_in = '0;
    logic       hit = 1'b0;
    logic       miss = 1'b0;
    logic [2:0] linesInSet_in = '0;
    logic [2:0] bTree_out;
    logic       bTree_valid;
    logic [1:0] index_out;
    logic       busy;
`ifdef PLRU_ERR_EN
    logic       err;
`endif

    int checks = 0;
    int errors = 0;

    plru_tree #(.SETWAY(SETWAY)) dut (
        .clk          (clk),
        .rst          (rst),
        .line_num     (line_num),
        .bTree_in     (bTree_in),
        .hit          (hit),
        .miss         (miss),
        .linesInSet_in(linesInSet_in),
        .bTree_out    (bTree_out),
        .bTree_valid  (bTree_valid),
        .index_out    (index_out),
`ifdef PLRU_ERR_EN
        .err          (err),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: fill/hit marks every ancestor of the target leaf bottom-up so each
    // parent points at the sibling subtree; victim search follows and flips bits top-down.
    function automatic void model(input logic h, input logic [1:0] line, input logic [2:0] tin,
                                  input logic [2:0] lines, output logic [2:0] tout,
                                  output logic [1:0] idx);
        int cl, n, p, tgt, b;
        cl   = (int'(lines) > SETWAY) ? SETWAY : int'(lines);
        tout = tin;
        if (!h && cl == SETWAY) begin
            n = 0;
            while (n < SETWAY - 1) begin
                b = int'(tout[n]);
                tout[n] = ~tout[n];
                n = 2 * n + 1 + b;
            end
            idx = 2'(n - (SETWAY - 1));
        end else begin
            tgt = h ? int'(line) : cl;
            idx = 2'(tgt);
            n   = tgt + SETWAY - 1;
            while (n > 0) begin
                p = (n - 1) / 2;
                tout[p] = (n == 2 * p + 1);
                n = p;
            end
        end
    endfunction

    task automatic do_req(input string name, input logic h, input logic m, input logic [1:0] ln,
                          input logic [2:0] tin, input logic [2:0] lines,
                          input logic [2:0] exp_tree, input logic [1:0] exp_idx);
        int  lat;
        bit  got;
        got = 0;
        lat = 0;
        @(negedge clk);
        hit = h; miss = m; line_num = ln; bTree_in = tin; linesInSet_in = lines;
        @(posedge clk);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check({name, " busy_walk"}, 32'(busy), 32'd1);
                // Scramble inputs while busy; they must be ignored.
                hit = ~h; miss = 1'($urandom); line_num = 2'($urandom);
                bTree_in = 3'($urandom); linesInSet_in = 3'($urandom);
            end
            if (bTree_valid) begin
                got = 1;
                lat = c;
                break;
            end
        end
        if (!got) begin
            check({name, " timeout"}, 32'd0, 32'd1);
        end else begin
            check({name, " latency"}, 32'(lat), 32'd2);
            check({name, " busy_done"}, 32'(busy), 32'd1);
            check({name, " tree"}, 32'(bTree_out), 32'(exp_tree));
            check({name, " index"}, 32'(index_out), 32'(exp_idx));
            hit = 1'b0; miss = 1'b0;
            @(negedge clk);
            check({name, " valid_pulse"}, 32'(bTree_valid), 32'd0);
            check({name, " idle"}, 32'(busy), 32'd0);
            check({name, " tree_hold"}, 32'(bTree_out), 32'(exp_tree));
        end
    endtask

    typedef struct {
        string      name;
        logic       h;
        logic       m;
        logic [1:0] ln;
        logic [2:0] tin;
        logic [2:0] lines;
        logic [2:0] exp_tree;
        logic [1:0] exp_idx;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [2:0] et;
        logic [1:0] ei;
        logic       rh;
        logic [1:0] rl;
        logic [2:0] rt, rn;

        vecs[0]  = '{"miss_000",      1'b0, 1'b1, 2'd0, 3'b000, 3'd4, 3'b011, 2'd0};
        vecs[1]  = '{"miss_011",      1'b0, 1'b1, 2'd0, 3'b011, 3'd4, 3'b110, 2'd2};
        vecs[2]  = '{"hit0_000",      1'b1, 1'b0, 2'd0, 3'b000, 3'd4, 3'b011, 2'd0};
        vecs[3]  = '{"hit3_111",      1'b1, 1'b0, 2'd3, 3'b111, 3'd4, 3'b010, 2'd3};
        vecs[4]  = '{"fill1_000",     1'b0, 1'b1, 2'd0, 3'b000, 3'd1, 3'b001, 2'd1};
        vecs[5]  = '{"miss_110",      1'b0, 1'b1, 2'd2, 3'b110, 3'd4, 3'b101, 2'd1};
        vecs[6]  = '{"miss_clamp7",   1'b0, 1'b1, 2'd0, 3'b111, 3'd7, 3'b010, 2'd3};
        vecs[7]  = '{"fill3_111",     1'b0, 1'b1, 2'd1, 3'b111, 3'd3, 3'b010, 2'd3};
        vecs[8]  = '{"hit2_000",      1'b1, 1'b0, 2'd2, 3'b000, 3'd4, 3'b100, 2'd2};
        vecs[9]  = '{"fill0_101",     1'b0, 1'b1, 2'd3, 3'b101, 3'd0, 3'b111, 2'd0};
        vecs[10] = '{"miss_clamp5",   1'b0, 1'b1, 2'd0, 3'b101, 3'd5, 3'b000, 2'd3};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst tree", 32'(bTree_out), 32'd0);
        check("rst index", 32'(index_out), 32'd0);
        check("rst valid", 32'(bTree_valid), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++)
            do_req(vecs[i].name, vecs[i].h, vecs[i].m, vecs[i].ln, vecs[i].tin,
                   vecs[i].lines, vecs[i].exp_tree, vecs[i].exp_idx);

        // Illegal hit=miss=1 and no request: nothing accepted, outputs hold.
        @(negedge clk);
        hit = 1'b1; miss = 1'b1; bTree_in = 3'b010; line_num = 2'd1; linesInSet_in = 3'd4;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("both busy", 32'(busy), 32'd0);
            check("both valid", 32'(bTree_valid), 32'd0);
        end
        hit = 1'b0; miss = 1'b0;
        @(negedge clk);
        check("none busy", 32'(busy), 32'd0);
        check("hold tree", 32'(bTree_out), 32'b000);
        check("hold index", 32'(index_out), 32'd3);

        // Reset during WALK aborts the request.
        hit = 1'b0; miss = 1'b1; bTree_in = 3'b000; linesInSet_in = 3'd4;
        @(posedge clk);
        @(negedge clk);
        hit = 1'b0; miss = 1'b0;
        check("abort busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort valid", 32'(bTree_valid), 32'd0);
        check("abort tree", 32'(bTree_out), 32'd0);
        check("abort index", 32'(index_out), 32'd0);
        begin
            bit seen;
            seen = 0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (bTree_valid || busy) seen = 1;
            end
            check("abort no_pulse", 32'(seen), 32'd0);
        end

        // Randomized requests against the reference model.
        for (int i = 0; i < 40; i++) begin
            rh = 1'($urandom);
            rl = 2'($urandom);
            rt = 3'($urandom);
            rn = 3'($urandom_range(0, 7));
            model(rh, rl, rt, rn, et, ei);
            do_req($sformatf("rand%0d", i), rh, ~rh, rl, rt, rn, et, ei);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/plru_tree.md
Name: plru_tree

Overview:
- Tree-based pseudo-LRU engine for one set of an n-way set-associative data cache.
- Caller supplies the set's current tree bits plus a hit or miss request.
- Block walks the binary tree one level per clock and returns the updated tree and the touched or victim way.
- Caller stores bTree_out back into the set's replacement-state array.

Parameters:
SETWAY, 4, ways per set; power of two, >=2
BITS_SETWAY, $clog2(SETWAY), bits to index a way (derived, not overridden)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
line_num  in  BITS_SETWAY  way hit (used on hit only)
bTree_in  in  SETWAY-1  current tree bits of the set
hit  in  1  hit request
miss  in  1  miss request (victim selection)
linesInSet_in  in  BITS_SETWAY+1  valid lines currently in set, 0..SETWAY
bTree_out  out  SETWAY-1  updated tree bits
bTree_valid  out  1  one-cycle pulse: bTree_out/index_out are new
index_out  out  BITS_SETWAY  way touched (hit) or victim (miss)
busy  out  1  high while request in flight; inputs ignored

Behaviour:
- Tree layout: node i has bit bTree[i]; children are 2i+1 (left) and 2i+2 (right). Leaf node n maps to way n-(SETWAY-1).
- Bit value 0 means the LRU side is left; 1 means right.
- FSM states: IDLE, WALK, DONE.
- IDLE: busy=0. A request is accepted on an edge with rst=0 and exactly one of hit/miss high.
  - On accept: capture bTree_in, line_num, hit/miss and clamped linesInSet_in (values >SETWAY treated as SETWAY); clear level counter; go to WALK.
  - hit=miss=0 or hit=miss=1: no accept, stay IDLE.
- Target way:
  - hit: target = line_num.
  - miss with clamped linesInSet_in < SETWAY: fill mode, target = linesInSet_in; walked like a hit on that way.
  - miss with full set: victim search.
- WALK: busy=1; one tree level per edge, BITS_SETWAY edges total.
  - Hit or fill: at each node, set bit=1 if target is in left subtree, else 0; descend toward target.
  - Victim search: if bit=0, set 1 and go left; else set 0 and go right.
  - After the last level, go to DONE with the updated tree and the leaf index registered.
- DONE: bTree_valid=1, busy=1 for exactly one cycle; next edge returns to IDLE.
- Latency: bTree_valid goes high BITS_SETWAY edges after the accept edge (2 for SETWAY=4). Throughput is one request per BITS_SETWAY+2 cycles.
- bTree_out and index_out hold their last values until the next DONE.
- Inputs are sampled only at accept; changes while busy have no effect.
- Reset values: state IDLE, bTree_out=0, index_out=0, bTree_valid=0, busy=0.
- Reset asserted mid-request aborts it; no valid pulse; outputs return to reset values.
- line_num is not range-checked against linesInSet_in on a hit; the update is applied as given.

Optional Feature:
PLRU_ERR_EN
- Defined: adds output err (1 bit, reset 0). err pulses for one cycle after any IDLE edge with hit=miss=1, or an accepted hit with line_num >= clamped linesInSet_in. The request itself is handled exactly as without the macro (illegal pair ignored, hit still applied).
- Undefined: no err port, no checking logic.

Test Plan (SETWAY=4, trees written {b2,b1,b0}):
- Reset: rst=1 for one edge -> bTree_out=000, index_out=0, bTree_valid=0, busy=0.
- Miss, bTree_in=000, linesInSet_in=4 -> after 2 edges bTree_valid=1, index_out=0, bTree_out=011; busy high from accept through DONE.
- Miss, bTree_in=011, linesInSet_in=4 -> index_out=2, bTree_out=110.
- Hit, line_num=0, bTree_in=000 -> index_out=0, bTree_out=011. Hit, line_num=3, bTree_in=111 -> index_out=3, bTree_out=010.
- Fill miss, linesInSet_in=1, bTree_in=000 -> index_out=1, bTree_out=001. hit=miss=1 in IDLE -> busy stays 0, no valid pulse.
- Accept a miss, toggle line_num/hit while busy -> result unchanged. Assert rst during WALK -> next cycle busy=0, no bTree_valid pulse.
